// File: rtl/rf_scoreboard.sv
// Multi-read-port register file with a per-register pending-write scoreboard.
// Decode reserves destinations; writeback writes results and releases them.
module rf_scoreboard #(
  parameter int AWL     = 5,
  parameter int DWL     = 32,
  parameter int NRP     = 2,
  parameter int ZERO_R0 = 1,
  parameter int BYPASS  = 1
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 RFWE,
  input  logic [AWL-1:0]       RFWA,
  input  logic [DWL-1:0]       RFWD,
  input  logic                 RSVE,
  input  logic [AWL-1:0]       RSVA,
  output logic                 RSVACK,
  input  logic [NRP*AWL-1:0]   RFRA,
  output logic [NRP*DWL-1:0]   RFRD,
  output logic [NRP-1:0]       RFBSY,
  output logic [AWL:0]         PCNT
);

  localparam int DEPTH = 2 ** AWL;

  logic [DWL-1:0]   mem_q [DEPTH];
  logic [DEPTH-1:0] busy_q, busy_d;
  logic [AWL:0]     pcnt_q, pcnt_d;

  logic wr_r0, rsv_r0;
  logic wr_en, rsv_set;
  logic inc, dec;

  assign wr_r0  = (ZERO_R0 != 0) && (RFWA == '0);
  assign rsv_r0 = (ZERO_R0 != 0) && (RSVA == '0);
  assign wr_en  = RFWE && !wr_r0;

  // Handshake: RSVE is the request, RSVACK the same-cycle grant. A reservation
  // takes effect only on an edge where both are high; a refused requester
  // simply holds RSVE and retries. A write to the same address in the same
  // cycle frees the slot, so the new reservation is granted immediately.
  assign RSVACK  = RSVE && (rsv_r0 || !busy_q[RSVA] || (RFWE && (RFWA == RSVA)));
  assign rsv_set = RSVACK && !rsv_r0;

  always_comb begin
    busy_d = busy_q;
    if (wr_en)   busy_d[RFWA] = 1'b0;
    if (rsv_set) busy_d[RSVA] = 1'b1;
  end

  // Count only real 0->1 and 1->0 transitions of the busy vector.
  assign inc = rsv_set && !busy_q[RSVA];
  assign dec = wr_en && busy_q[RFWA] && !(rsv_set && (RSVA == RFWA));

  assign pcnt_d = pcnt_q + (AWL+1)'(inc) - (AWL+1)'(dec);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      busy_q <= '0;
      pcnt_q <= '0;
    end else begin
      if (wr_en) mem_q[RFWA] <= RFWD;
      busy_q <= busy_d;
      pcnt_q <= pcnt_d;
    end
  end

  assign PCNT = pcnt_q;

  for (genvar p = 0; p < NRP; p++) begin : g_rd
    logic [AWL-1:0] ra;
    logic [DWL-1:0] rd;
    logic           bsy;

    assign ra = RFRA[p*AWL +: AWL];

    // Hardwired zero has priority over the write-through path.
    always_comb begin
      rd  = mem_q[ra];
      bsy = busy_q[ra];
      if ((BYPASS != 0) && RFWE && (RFWA == ra)) begin
        rd  = RFWD;
        bsy = 1'b0;
      end
      if ((ZERO_R0 != 0) && (ra == '0)) begin
        rd  = '0;
        bsy = 1'b0;
      end
    end

    assign RFRD[p*DWL +: DWL] = rd;
    assign RFBSY[p]           = bsy;
  end

endmodule

// File: tb/tb_rf_scoreboard.sv
// Directed bench for rf_scoreboard: a 4-port bypassing instance and a 2-port
// non-bypassing instance, checked against hand-computed values and a data model.
module tb_rf_scoreboard;

  logic CLK = 1'b0;
  logic RST;

  always #5 CLK = ~CLK;

  // 4-port, bypassing instance
  logic         we, rsve, rsvack;
  logic [4:0]   wa, rsva;
  logic [31:0]  wd;
  logic [19:0]  rfra;
  logic [127:0] rfrd;
  logic [3:0]   rfbsy;
  logic [5:0]   pcnt;

  // 2-port, non-bypassing instance
  logic         b_we, b_rsve, b_rsvack;
  logic [4:0]   b_wa, b_rsva;
  logic [31:0]  b_wd;
  logic [9:0]   b_rfra;
  logic [63:0]  b_rfrd;
  logic [1:0]   b_rfbsy;
  logic [5:0]   b_pcnt;

  rf_scoreboard #(.AWL(5), .DWL(32), .NRP(4), .ZERO_R0(1), .BYPASS(1)) u_dut (
    .CLK(CLK), .RST(RST),
    .RFWE(we), .RFWA(wa), .RFWD(wd),
    .RSVE(rsve), .RSVA(rsva), .RSVACK(rsvack),
    .RFRA(rfra), .RFRD(rfrd), .RFBSY(rfbsy), .PCNT(pcnt)
  );

  rf_scoreboard #(.AWL(5), .DWL(32), .NRP(2), .ZERO_R0(1), .BYPASS(0)) u_nobyp (
    .CLK(CLK), .RST(RST),
    .RFWE(b_we), .RFWA(b_wa), .RFWD(b_wd),
    .RSVE(b_rsve), .RSVA(b_rsva), .RSVACK(b_rsvack),
    .RFRA(b_rfra), .RFRD(b_rfrd), .RFBSY(b_rfbsy), .PCNT(b_pcnt)
  );

  // scoreboard
  int          n_vec = 0;
  int          n_bad = 0;
  logic [31:0] exp_q[$];
  logic [31:0] model_mem[32];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rd(input int p);
    return rfrd[p*32 +: 32];
  endfunction

  function automatic logic [31:0] bsy(input int p);
    return 32'(rfbsy[p]);
  endfunction

  // driver tasks
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    we = 1'b0; wa = '0; wd = '0; rsve = 1'b0; rsva = '0;
    b_we = 1'b0; b_wa = '0; b_wd = '0; b_rsve = 1'b0; b_rsva = '0;
  endtask

  task automatic set_ra(input int p, input logic [4:0] a);
    rfra[p*5 +: 5] = a;
  endtask

  initial begin
    logic [4:0]  a;
    logic [31:0] d;

    // clock / reset
    RST = 1'b1;
    idle();
    rfra   = '0;
    b_rfra = '0;
    for (int i = 0; i < 32; i++) model_mem[i] = '0;
    rsve = 1'b1; rsva = 5'd9;
    repeat (2) tick();
    check_eq("rst_pcnt", 32'(pcnt), 32'd0);
    check_eq("rst_rsvack", 32'(rsvack), 32'd1);
    rsve = 1'b0;
    RST  = 1'b0;

    // every address on every port reads zero / not busy
    for (int i = 0; i < 32; i++) begin
      a = 5'(i);
      rfra = {4{a}};
      #1;
      for (int p = 0; p < 4; p++) begin
        check_eq("sweep_rd", rd(p), 32'd0);
        check_eq("sweep_bsy", bsy(p), 32'd0);
      end
    end

    // reserve r5, then see it busy
    rfra = '0;
    set_ra(0, 5'd5);
    rsve = 1'b1; rsva = 5'd5;
    #1 check_eq("rsv5_ack", 32'(rsvack), 32'd1);
    tick();
    rsve = 1'b0;
    #1;
    check_eq("rsv5_bsy", bsy(0), 32'd1);
    check_eq("rsv5_pcnt", 32'(pcnt), 32'd1);

    // refused reserve of a busy register
    rsve = 1'b1; rsva = 5'd5;
    #1 check_eq("rsv5_refuse", 32'(rsvack), 32'd0);
    tick();
    rsve = 1'b0;
    #1 check_eq("refuse_pcnt", 32'(pcnt), 32'd1);

    // write and reserve r5 in the same cycle: new reservation wins
    rsve = 1'b1; rsva = 5'd5;
    we = 1'b1; wa = 5'd5; wd = 32'hA5A5_0001;
    #1;
    check_eq("wr_rsv_ack", 32'(rsvack), 32'd1);
    check_eq("wr_rsv_byp", rd(0), 32'hA5A5_0001);
    check_eq("wr_rsv_bypbsy", bsy(0), 32'd0);
    tick();
    idle();
    #1;
    check_eq("wr_rsv_rd", rd(0), 32'hA5A5_0001);
    check_eq("wr_rsv_bsy", bsy(0), 32'd1);
    check_eq("wr_rsv_pcnt", 32'(pcnt), 32'd1);

    // writeback releases r5, data visible through bypass
    we = 1'b1; wa = 5'd5; wd = 32'hDEAD_BEEF;
    #1;
    check_eq("wb5_byp", rd(0), 32'hDEAD_BEEF);
    check_eq("wb5_bypbsy", bsy(0), 32'd0);
    check_eq("wb5_pcnt_pre", 32'(pcnt), 32'd1);
    tick();
    idle();
    #1;
    check_eq("wb5_pcnt", 32'(pcnt), 32'd0);
    check_eq("wb5_rd", rd(0), 32'hDEAD_BEEF);
    check_eq("wb5_bsy", bsy(0), 32'd0);
    model_mem[5] = 32'hDEAD_BEEF;

    // r0 is hardwired: write and reserve have no effect
    set_ra(0, 5'd0);
    we = 1'b1; wa = 5'd0; wd = 32'hFFFF_FFFF;
    rsve = 1'b1; rsva = 5'd0;
    #1;
    check_eq("r0_ack", 32'(rsvack), 32'd1);
    check_eq("r0_byp", rd(0), 32'd0);
    check_eq("r0_bypbsy", bsy(0), 32'd0);
    tick();
    idle();
    #1;
    check_eq("r0_rd", rd(0), 32'd0);
    check_eq("r0_bsy", bsy(0), 32'd0);
    check_eq("r0_pcnt", 32'(pcnt), 32'd0);

    // reserve r1..r31 back to back
    for (int i = 1; i < 32; i++) begin
      rsve = 1'b1; rsva = 5'(i);
      #1 check_eq("fill_ack", 32'(rsvack), 32'd1);
      tick();
    end
    rsve = 1'b1; rsva = 5'd0;
    #1 check_eq("full_r0_ack", 32'(rsvack), 32'd1);
    tick();
    idle();
    #1 check_eq("full_pcnt", 32'(pcnt), 32'd31);

    // release in reverse order
    for (int i = 31; i >= 1; i--) begin
      d = 32'hC0DE_0000 | 32'(i);
      we = 1'b1; wa = 5'(i); wd = d;
      set_ra(0, 5'(i));
      set_ra(1, (i == 31) ? 5'd0 : 5'(i + 1));
      set_ra(2, 5'(i - 1));
      set_ra(3, 5'd0);
      #1;
      check_eq("rev_byp", rd(0), d);
      check_eq("rev_prev", rd(1), model_mem[(i == 31) ? 0 : i + 1]);
      check_eq("rev_nextbsy", bsy(2), (i > 1) ? 32'd1 : 32'd0);
      check_eq("rev_zero", rd(3), 32'd0);
      tick();
      model_mem[i] = d;
      we = 1'b0;
      #1 check_eq("rev_pcnt", 32'(pcnt), 32'(i - 1));
    end

    // random addresses on all ports against the data model
    for (int k = 0; k < 24; k++) begin
      for (int p = 0; p < 4; p++) begin
        a = 5'($urandom_range(0, 31));
        set_ra(p, a);
        exp_q.push_back(model_mem[a]);
      end
      #1;
      for (int p = 0; p < 4; p++) begin
        check_eq("rand_rd", rd(p), exp_q.pop_front());
        check_eq("rand_bsy", bsy(p), 32'd0);
      end
      tick();
    end

    // non-bypassing build: write cycle shows old value and old busy
    b_rfra = {5'd0, 5'd3};
    b_we = 1'b1; b_wa = 5'd3; b_wd = 32'h12;
    #1;
    check_eq("nb_old", b_rfrd[31:0], 32'd0);
    check_eq("nb_oldbsy", 32'(b_rfbsy[0]), 32'd0);
    tick();
    b_we = 1'b0;
    #1 check_eq("nb_new", b_rfrd[31:0], 32'h12);
    b_rsve = 1'b1; b_rsva = 5'd3;
    #1 check_eq("nb_ack", 32'(b_rsvack), 32'd1);
    tick();
    b_rsve = 1'b0;
    #1;
    check_eq("nb_bsy", 32'(b_rfbsy[0]), 32'd1);
    check_eq("nb_pcnt", 32'(b_pcnt), 32'd1);
    b_we = 1'b1; b_wd = 32'h34;
    #1;
    check_eq("nb_wr_old", b_rfrd[31:0], 32'h12);
    check_eq("nb_wr_oldbsy", 32'(b_rfbsy[0]), 32'd1);
    tick();
    b_we = 1'b0;
    #1;
    check_eq("nb_wr_new", b_rfrd[31:0], 32'h34);
    check_eq("nb_wr_bsy", 32'(b_rfbsy[0]), 32'd0);
    check_eq("nb_wr_pcnt", 32'(b_pcnt), 32'd0);

    // asynchronous reset in the middle of a cycle
    rsve = 1'b1; rsva = 5'd9;
    tick();
    rsve = 1'b0;
    #1 check_eq("pre_rst_pcnt", 32'(pcnt), 32'd1);
    set_ra(0, 5'd12);
    set_ra(1, 5'd9);
    set_ra(2, 5'd7);
    set_ra(3, 5'd5);
    we = 1'b1; wa = 5'd7; wd = 32'h55;
    rsve = 1'b1; rsva = 5'd9;
    #1 RST = 1'b1;
    #1;
    check_eq("arst_pcnt", 32'(pcnt), 32'd0);
    check_eq("arst_rd12", rd(0), 32'd0);
    check_eq("arst_bsy9", bsy(1), 32'd0);
    check_eq("arst_byp7", rd(2), 32'h55);
    check_eq("arst_rd5", rd(3), 32'd0);
    check_eq("arst_ack", 32'(rsvack), 32'd1);
    check_eq("arst_nb", b_rfrd[31:0], 32'd0);
    tick();
    idle();
    RST = 1'b0;
    #1;
    check_eq("post_rst_rd7", rd(2), 32'd0);
    check_eq("post_rst_bsy9", bsy(1), 32'd0);
    check_eq("post_rst_pcnt", 32'(pcnt), 32'd0);

    // final report
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
